uart_program_loader: RTL and testbench
======================================

// Module: uart_program_loader
// PURPOSE
//  Serial program loader: receives 8N1 UART packets and writes them into the CPU's program/data memory.
//  It holds the CPU while a packet arrives, then restarts the CPU on a clean load.
//  Sits beside the CPU core, on the write side of memory; the CPU reads that memory through the MAR path.
//  On a valid packet it pulses cpu_rst so the PC restarts at 0 with the new image.
// PARAMETERS
//  CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200); must be >= 4
//  ADDR_W        4    memory address width; DEPTH = 2**ADDR_W bytes
//  HEADER        8'hA5  packet start byte
// PORTS
//  clk         in   1       system clock, undivided; all logic on posedge
//  rst_btn     in   1       asynchronous reset, active-low
//  rx          in   1       UART line, idle high, asynchronous to clk
//  mem_addr    out  ADDR_W  write address into program memory
//  mem_data    out  8       write data
//  mem_we      out  1       one-cycle write strobe
//  cpu_hold    out  1       1 = CPU clock gated (drives CPU hlt OR-term)
//  cpu_rst     out  1       one-cycle CPU reset pulse after a good load
//  load_done   out  1       one-cycle pulse: packet accepted
//  load_err    out  1       sticky error flag; cleared by next accepted header
//  byte_count  out  ADDR_W+1  data bytes written in current/last packet
// BEHAVIOUR
//  Reset (rst_btn=0, async): all outputs 0. State IDLE. RX sampler idle. cpu_hold=0, so the existing memory image runs.
//  RX front end:
//   - rx passes through a 2-FF synchroniser.
//   - Falling edge starts the bit timer. Start bit is re-checked at CLKS_PER_BIT/2; if high, it is a glitch: return to idle, no byte.
//   - Data bits are sampled LSB first at mid-bit. The stop bit is sampled at mid-bit.
//   - Stop=1: byte_valid pulses for 1 clk with the byte.
//   - Stop=0: framing error pulse, no byte.
//   - The receiver rearms immediately after the stop-bit sample, so back-to-back frames are supported.
//  Packet format: HEADER, LEN, LEN data bytes, CSUM. Valid iff (LEN + sum(data) + CSUM) mod 256 == 0.
//  FSM, advanced only on byte_valid/frame_err:
//   IDLE: byte==HEADER -> LEN; set cpu_hold=1, clear load_err, byte_count=0. Other bytes and framing errors are ignored.
//   LEN : 1<=byte<=DEPTH -> DATA, sum=byte. Otherwise -> ERR.
//   DATA: write byte to addr=byte_count.
//         - mem_we, mem_addr and mem_data are valid for exactly the clk after byte_valid.
//         - byte_count++ and sum+=byte (8-bit wrap).
//         - After LEN bytes -> CSUM.
//   CSUM: (sum+byte)==0 -> DONE, else -> ERR.
//   DONE: one clk. load_done=1, cpu_rst=1. cpu_hold drops to 0 in the same cycle as the pulses. -> IDLE.
//   ERR : load_err=1. cpu_hold stays 1, so the partial image never runs. HEADER byte -> LEN (restart load).
//  Framing error in LEN/DATA/CSUM -> ERR. Framing error in IDLE/ERR is ignored.
//  A HEADER value appearing as LEN/DATA/CSUM is treated as data, not a restart.
//  Memory beyond LEN is untouched. Addresses never wrap: LEN<=DEPTH is enforced.
//  Async reset mid-packet aborts immediately. cpu_hold=0; memory keeps already-written bytes.
//  Latency: last stop-bit sample to load_done = 1 clk.
// STRUCTURE
//  Sub-module uart_rx (synchroniser, bit timer, shift reg; outputs byte, byte_valid, frame_err).
//  Top holds the packet FSM, checksum and write port.
//  Shared package/header: FSM state localparams (IDLE, LEN, DATA, CSUM, DONE, ERR), HEADER default, 8N1 bit-count constant.
// TESTING
//  Use CLKS_PER_BIT=8 for sim speed.
//  1. A5 02 11 22 CB -> mem_we at addr0=11, addr1=22; load_done and cpu_rst pulse once; cpu_hold 1->0; load_err=0; byte_count=2.
//  2. A5 02 11 22 CC -> two writes occur; no load_done; load_err=1, cpu_hold=1. Then test 1 packet -> load_err clears, load_done pulses.
//  3. Junk 00 FF 5A, then test 1 packet -> junk ignored (no writes, cpu_hold 0 until A5); then normal load.
//  4. A5 00 and A5 11 (DEPTH=16) -> ERR with no mem_we. A5 10 + 16 bytes + valid csum -> addr 0..15 written, done.
//  5. Stop bit forced 0 on second data byte -> ERR, load_err=1. A 1/4-bit low glitch on idle rx produces no byte.
//  6. Assert rst_btn mid-DATA -> all outputs 0 within same cycle; fresh test 1 packet then loads correctly.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader: packet FSM states,
// receiver states, default header byte and 8N1 frame constants.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } ld_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    localparam logic [7:0]  HeaderDefault = 8'hA5;
    localparam int unsigned FrameDataBits = 8;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling bit timer and LSB-first
// shift register. byte_valid_o / frame_err_o are single-cycle strobes on the stop sample.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e       state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RxStart;
                end
            end
            RxStart: begin
                // Start bit must still be low at mid-bit, otherwise it was a glitch.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(FrameDataBits - 1)) begin
                        state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d        = '0;
                    state_d      = RxIdle;
                    byte_valid_o = sync2_q;
                    frame_err_o  = !sync2_q;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_byte_o = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: parses HEADER/LEN/data/CSUM packets from uart_rx, writes the
// data bytes into program memory, holds the CPU during a load and restarts it on success.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned ADDR_W       = 4,
    parameter logic [7:0]  HEADER       = HeaderDefault
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CntW     = ADDR_W + 1;
    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [8:0]  DepthMax = 9'(Depth);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i        (clk),
        .rst_ni       (rst_btn),
        .rx_i         (rx),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    ld_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CntW-1:0]   len_q, len_d;
    logic [7:0]        sum_q, sum_d, sum_next;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign cnt_inc  = cnt_q + 1'b1;
    assign sum_next = sum_q + rx_byte;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            // Framing errors are ignored while waiting for a header.
            StIdle, StErr: begin
                if (byte_valid && rx_byte == HEADER) begin
                    state_d = StLen;
                    cnt_d   = '0;
                end
            end
            StLen: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (byte_valid) begin
                    if (rx_byte != 8'h00 && {1'b0, rx_byte} <= DepthMax) begin
                        state_d = StData;
                        len_d   = CntW'(rx_byte);
                        sum_d   = rx_byte;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StData: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (byte_valid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[ADDR_W-1:0];
                    data_d = rx_byte;
                    cnt_d  = cnt_inc;
                    sum_d  = sum_next;
                    if (cnt_inc == len_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (byte_valid) begin
                    state_d = (sum_next == 8'h00) ? StDone : StErr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Hold covers error state too so a partial image never runs.
    assign cpu_hold   = (state_q == StLen) || (state_q == StData) ||
                        (state_q == StCsum) || (state_q == StErr);
    assign load_done  = (state_q == StDone);
    assign cpu_rst    = (state_q == StDone);
    assign load_err   = (state_q == StErr);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: drives 8N1 frames on rx and checks memory
// writes, CPU hold/restart pulses and error flag against hand-computed expectations.
module tb_uart_program_loader;

    localparam int unsigned Cpb   = 8;
    localparam int unsigned AddrW = 4;

    logic             clk = 1'b0;
    logic             rst_btn = 1'b0;
    logic             rx = 1'b1;
    logic [AddrW-1:0] mem_addr;
    logic [7:0]       mem_data;
    logic             mem_we;
    logic             cpu_hold;
    logic             cpu_rst;
    logic             load_done;
    logic             load_err;
    logic [AddrW:0]   byte_count;

    uart_program_loader #(
        .CLKS_PER_BIT (Cpb),
        .ADDR_W       (AddrW),
        .HEADER       (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_btn    (rst_btn),
        .rx         (rx),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    int         done_cnt = 0;
    int         rst_cnt = 0;
    int         hold_at_done = 0;
    logic [7:0] mem_sh [16];
    int         b_we, b_done, b_rst;

    // Observe outputs mid-cycle; record writes into a shadow memory.
    always @(negedge clk) begin
        if (mem_we) begin
            mem_sh[mem_addr] = mem_data;
            we_cnt = we_cnt + 1;
        end
        if (load_done) done_cnt = done_cnt + 1;
        if (cpu_rst) rst_cnt = rst_cnt + 1;
        if (load_done && cpu_hold) hold_at_done = hold_at_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop_bit;
        repeat (Cpb) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_good_pkt();
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
        idle(8);
    endtask

    task automatic snap();
        b_we   = we_cnt;
        b_done = done_cnt;
        b_rst  = rst_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_flags", 32'({mem_we, cpu_rst, load_done, load_err}), 0);
        check("rst_count", 32'(byte_count), 0);
        check("rst_addr_data", 32'({mem_addr, mem_data}), 0);
        rst_btn = 1'b1;
        idle(8);

        // Test 1: good load
        snap();
        send(8'hA5); send(8'h02);
        check("t1_hold_mid", 32'(cpu_hold), 1);
        send(8'h11); send(8'h22); send(8'hCB);
        idle(8);
        check("t1_we", 32'(we_cnt - b_we), 2);
        check("t1_mem0", 32'(mem_sh[0]), 32'h11);
        check("t1_mem1", 32'(mem_sh[1]), 32'h22);
        check("t1_done", 32'(done_cnt - b_done), 1);
        check("t1_cpurst", 32'(rst_cnt - b_rst), 1);
        check("t1_hold", 32'(cpu_hold), 0);
        check("t1_err", 32'(load_err), 0);
        check("t1_count", 32'(byte_count), 2);

        // Test 2: bad checksum, then recovery
        snap();
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCC);
        idle(8);
        check("t2_we", 32'(we_cnt - b_we), 2);
        check("t2_done", 32'(done_cnt - b_done), 0);
        check("t2_err", 32'(load_err), 1);
        check("t2_hold", 32'(cpu_hold), 1);
        snap();
        send_good_pkt();
        check("t2_rec_err", 32'(load_err), 0);
        check("t2_rec_done", 32'(done_cnt - b_done), 1);
        check("t2_rec_hold", 32'(cpu_hold), 0);

        // Test 3: junk ignored in idle
        snap();
        send(8'h00); send(8'hFF); send(8'h5A);
        idle(8);
        check("t3_hold", 32'(cpu_hold), 0);
        check("t3_we", 32'(we_cnt - b_we), 0);
        check("t3_err", 32'(load_err), 0);
        send_good_pkt();
        check("t3_done", 32'(done_cnt - b_done), 1);

        // Test 4: LEN bounds and full-depth load
        snap();
        send(8'hA5); send(8'h00);
        idle(8);
        check("t4_len0_err", 32'(load_err), 1);
        send(8'hA5); send(8'h11);
        idle(8);
        check("t4_len17_err", 32'(load_err), 1);
        check("t4_len_we", 32'(we_cnt - b_we), 0);
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        send(8'h78);
        idle(8);
        check("t4_full_we", 32'(we_cnt - b_we), 16);
        check("t4_mem0", 32'(mem_sh[0]), 32'h10);
        check("t4_mem7", 32'(mem_sh[7]), 32'h17);
        check("t4_mem15", 32'(mem_sh[15]), 32'h1F);
        check("t4_count", 32'(byte_count), 16);
        check("t4_done", 32'(done_cnt - b_done), 1);
        check("t4_err", 32'(load_err), 0);
        // Header value as data is not a restart
        snap();
        send(8'hA5); send(8'h01); send(8'hA5); send(8'h5A);
        idle(8);
        check("t4_hdr_data", 32'(mem_sh[0]), 32'hA5);
        check("t4_hdr_done", 32'(done_cnt - b_done), 1);

        // Test 5: framing error on second data byte, then glitch tolerance
        snap();
        send(8'hA5); send(8'h02); send(8'h11); send_byte(8'h22, 1'b0);
        idle(16);
        check("t5_ferr_err", 32'(load_err), 1);
        check("t5_ferr_we", 32'(we_cnt - b_we), 1);
        check("t5_ferr_count", 32'(byte_count), 1);
        check("t5_ferr_done", 32'(done_cnt - b_done), 0);
        snap();
        send(8'hA5);
        rx = 1'b0;
        repeat (Cpb / 4) @(negedge clk);
        idle(24);
        check("t5_glitch_err", 32'(load_err), 0);
        send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
        idle(8);
        check("t5_glitch_done", 32'(done_cnt - b_done), 1);
        check("t5_glitch_we", 32'(we_cnt - b_we), 2);

        // Test 6: async reset mid-DATA
        send(8'hA5); send(8'h02); send(8'h11);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst_btn = 1'b0;
        #1;
        check("t6_rst_hold", 32'(cpu_hold), 0);
        check("t6_rst_count", 32'(byte_count), 0);
        check("t6_rst_flags", 32'({mem_we, cpu_rst, load_done, load_err}), 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_btn = 1'b1;
        idle(16);
        snap();
        send_good_pkt();
        check("t6_done", 32'(done_cnt - b_done), 1);
        check("t6_count", 32'(byte_count), 2);
        check("t6_mem1", 32'(mem_sh[1]), 32'h22);
        check("hold_at_done", 32'(hold_at_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
